// File: rtl/fu_cdb_scheduler_if.sv
// FU scheduler bus: issue/done from the RS and FUs, ready/grant/CDB back.
// master = RS/FU side, slave = scheduler side.
interface fu_cdb_scheduler_if #(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3,
    parameter int PRW    = 6
);
    logic                    flush;
    logic [NUM_FU-1:0]       fu_issue;
    logic [NUM_FU*PRW-1:0]   fu_dest_pr;
    logic [NUM_FU-1:0]       fu_done;
    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_FU-1:0]       fu_grant;
    logic [CDB_W-1:0]        cdb_valid;
    logic [CDB_W*PRW-1:0]    cdb_tag;
    logic                    issue_err;

    modport master (
        output flush, fu_issue, fu_dest_pr, fu_done,
        input  fu_ready, fu_grant, cdb_valid, cdb_tag, issue_err
    );

    modport slave (
        input  flush, fu_issue, fu_dest_pr, fu_done,
        output fu_ready, fu_grant, cdb_valid, cdb_tag, issue_err
    );
endinterface

// File: rtl/fu_cdb_scheduler.sv
// FU occupancy tracking and round-robin CDB arbitration.
// FU_SCHED_FAST_DONE_EN: BUSY+done FUs may win the CDB in the same cycle.
module fu_cdb_scheduler #(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3,
    parameter int PRW    = 6
) (
    input logic               clock,
    input logic               reset,
    fu_cdb_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_FU);
`ifdef FU_SCHED_FAST_DONE_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WAIT = 2'd2
    } fu_state_e;

    fu_state_e            state_q [NUM_FU];
    fu_state_e            state_d [NUM_FU];
    logic [PRW-1:0]       tag_q   [NUM_FU];
    logic [PRW-1:0]       tag_d   [NUM_FU];
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [CDB_W-1:0]     valid_q, valid_d;
    logic [CDB_W*PRW-1:0] ctag_q, ctag_d;
    logic                 err_q, err_d;
    logic [NUM_FU-1:0]    ready;
    logic [NUM_FU-1:0]    grant;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = (state_q[i] == S_IDLE);
        end
    end

    // Pass 0 scans WAIT FUs; the optional pass 1 fills leftover slots
    // with BUSY FUs whose done is already up.
    always_comb begin
        int               cnt;
        logic [PTR_W-1:0] idx;
        logic             cand;
        grant   = '0;
        valid_d = '0;
        ctag_d  = '0;
        rr_d    = rr_q;
        cnt     = 0;
        idx     = '0;
        cand    = 1'b0;
        for (int p = 0; p < NPASS; p++) begin
            for (int k = 0; k < NUM_FU; k++) begin
                idx  = PTR_W'((int'(rr_q) + k) % NUM_FU);
                cand = (p == 0) ? (state_q[idx] == S_WAIT)
                                : (state_q[idx] == S_BUSY && bus.fu_done[idx]);
                if (!bus.flush && cand && cnt < CDB_W) begin
                    grant[idx] = 1'b1;
                    for (int s = 0; s < CDB_W; s++) begin
                        if (s == cnt) begin
                            valid_d[s]            = 1'b1;
                            ctag_d[s*PRW +: PRW] = tag_q[idx];
                        end
                    end
                    cnt  = cnt + 1;
                    rr_d = PTR_W'((int'(idx) + 1) % NUM_FU);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            if (bus.flush) begin
                state_d[i] = S_IDLE;
                tag_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    S_IDLE: if (bus.fu_issue[i]) begin
                        state_d[i] = S_BUSY;
                        tag_d[i]   = bus.fu_dest_pr[i*PRW +: PRW];
                    end
`ifdef FU_SCHED_FAST_DONE_EN
                    S_BUSY: if (grant[i]) state_d[i] = S_IDLE;
                            else if (bus.fu_done[i]) state_d[i] = S_WAIT;
`else
                    S_BUSY: if (bus.fu_done[i]) state_d[i] = S_WAIT;
`endif
                    S_WAIT: if (grant[i]) state_d[i] = S_IDLE;
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
        err_d = err_q | (~bus.flush & |(bus.fu_issue & ~ready));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= S_IDLE;
                tag_q[i]   <= '0;
            end
            rr_q    <= '0;
            valid_q <= '0;
            ctag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
            end
            rr_q    <= rr_d;
            valid_q <= valid_d;
            ctag_q  <= ctag_d;
            err_q   <= err_d;
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.fu_grant  = grant;
    assign bus.cdb_valid = valid_q;
    assign bus.cdb_tag   = ctag_q;
    assign bus.issue_err = err_q;
endmodule

// File: tb/tb_fu_cdb_scheduler.sv
// Scoreboard bench for fu_cdb_scheduler: expected CDB beats are queued
// at stimulus time and popped by a negedge monitor.
module tb_fu_cdb_scheduler;
    logic clock;
    logic reset;
    int   vectors = 0;
    int   miscmp  = 0;
    int   cyc     = 0;

    typedef struct {
        logic [2:0]  v;
        logic [17:0] t;
        int          c;
    } exp_t;
    exp_t sb[$];

    fu_cdb_scheduler_if bus ();

    fu_cdb_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] v, input logic [5:0] t0,
                        input logic [5:0] t1, input logic [5:0] t2,
                        input int c);
        exp_t e;
        e.v = v;
        e.t = {t2, t1, t0};
        e.c = c;
        sb.push_back(e);
    endtask

    // The FUs drop fu_done on the edge after their grant.
    task automatic step();
        logic [7:0] g;
        @(negedge clock);
        g = bus.fu_grant;
        @(posedge clock);
        #1;
        bus.fu_done = bus.fu_done & ~g;
    endtask

    task automatic set_tag(input int i, input logic [5:0] t);
        bus.fu_dest_pr[i*6 +: 6] = t;
    endtask

    task automatic issue(input logic [7:0] m);
        bus.fu_issue = m;
        step();
        bus.fu_issue = '0;
    endtask

    always @(negedge clock) begin
        if (reset && bus.cdb_valid != '0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscmp++;
                $display("FAIL cdb_unexpected: got v=%b t=%h at cyc %0d want none",
                         bus.cdb_valid, bus.cdb_tag, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.cdb_valid !== e.v || bus.cdb_tag !== e.t || cyc != e.c) begin
                    miscmp++;
                    $display("FAIL cdb_beat: got v=%b t=%h cyc %0d want v=%b t=%h cyc %0d",
                             bus.cdb_valid, bus.cdb_tag, cyc, e.v, e.t, e.c);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        bus.flush      = 1'b0;
        bus.fu_issue   = '0;
        bus.fu_dest_pr = '0;
        bus.fu_done    = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(bus.fu_ready), 32'hFF);
        chk("rst_cdb", 32'(bus.cdb_valid), 32'h0);
        chk("rst_err", 32'(bus.issue_err), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_outs", {bus.fu_ready, 5'(bus.cdb_valid), 1'(bus.issue_err)},
                {8'hFF, 5'h0, 1'b0});
        end

        // single op on FU0
        set_tag(0, 6'd5);
        issue(8'h01);
        chk("fu0_busy", 32'(bus.fu_ready), 32'hFE);
        step();
        step();
        bus.fu_done = 8'h01;
        push(3'b001, 6'd5, 6'd0, 6'd0, cyc + 2);
        step();
        chk("fu0_grant", 32'(bus.fu_grant), 32'h01);
        chk("fu0_wait_ready", 32'(bus.fu_ready), 32'hFE);
        step();
        chk("fu0_free", 32'(bus.fu_ready), 32'hFF);

        // FU7: grant, then reissue next cycle; leaves rr_ptr at 0
        set_tag(7, 6'd9);
        issue(8'h80);
        bus.fu_done = 8'h80;
        push(3'b001, 6'd9, 6'd0, 6'd0, cyc + 2);
        step();
        chk("fu7_grant", 32'(bus.fu_grant), 32'h80);
        step();
        chk("fu7_free", 32'(bus.fu_ready), 32'hFF);
        set_tag(7, 6'd21);
        issue(8'h80);
        chk("fu7_reissue", 32'(bus.fu_ready), 32'h7F);
        chk("fu7_no_err", 32'(bus.issue_err), 32'h0);

        // all 8 FUs in WAIT together
        for (int i = 0; i < 7; i++) set_tag(i, 6'(10 + i));
        issue(8'h7F);
        chk("all_busy", 32'(bus.fu_ready), 32'h00);
        bus.fu_done = 8'hFF;
        push(3'b111, 6'd10, 6'd11, 6'd12, cyc + 2);
        push(3'b111, 6'd13, 6'd14, 6'd15, cyc + 3);
        push(3'b011, 6'd16, 6'd21, 6'd0, cyc + 4);
        step();
        chk("rr_grant1", 32'(bus.fu_grant), 32'h07);
        step();
        chk("rr_grant2", 32'(bus.fu_grant), 32'h38);
        step();
        chk("rr_grant3", 32'(bus.fu_grant), 32'hC0);
        step();
        chk("rr_drained", {bus.fu_grant, bus.fu_ready}, {8'h00, 8'hFF});

        // flush with 4 FUs in WAIT
        for (int i = 0; i < 4; i++) set_tag(i, 6'(40 + i));
        issue(8'h0F);
        bus.fu_done = 8'h0F;
        step();
        bus.flush = 1'b1;
        #1;
        chk("flush_no_grant", 32'(bus.fu_grant), 32'h0);
        step();
        bus.flush   = 1'b0;
        bus.fu_done = '0;
        chk("flush_ready", 32'(bus.fu_ready), 32'hFF);
        chk("flush_cdb", 32'(bus.cdb_valid), 32'h0);
        repeat (3) step();

        // rr_ptr still 0 after the flush
        for (int i = 0; i < 4; i++) set_tag(i, 6'(50 + i));
        issue(8'h0F);
        bus.fu_done = 8'h0F;
        push(3'b111, 6'd50, 6'd51, 6'd52, cyc + 2);
        push(3'b001, 6'd53, 6'd0, 6'd0, cyc + 3);
        repeat (3) step();

        // issue to a busy FU5: ignored, error sticky, old tag kept
        set_tag(5, 6'd33);
        issue(8'h20);
        set_tag(5, 6'd44);
        issue(8'h20);
        chk("err_set", 32'(bus.issue_err), 32'h1);
        chk("err_ready", 32'(bus.fu_ready), 32'hDF);
        bus.fu_done = 8'h20;
        push(3'b001, 6'd33, 6'd0, 6'd0, cyc + 2);
        step();
        step();
        chk("err_sticky", 32'(bus.issue_err), 32'h1);

        // rr_ptr=6: order 6,7,0 then 1 (wrap)
        set_tag(0, 6'd60);
        set_tag(1, 6'd61);
        set_tag(6, 6'd62);
        set_tag(7, 6'd63);
        issue(8'hC3);
        bus.fu_done = 8'hC3;
        push(3'b111, 6'd62, 6'd63, 6'd60, cyc + 2);
        push(3'b001, 6'd61, 6'd0, 6'd0, cyc + 3);
        step();
        chk("wrap_grant", 32'(bus.fu_grant), 32'hC1);
        step();
        step();

        // async reset while the CDB is full
        for (int i = 0; i < 3; i++) set_tag(i, 6'(1 + i));
        issue(8'h07);
        bus.fu_done = 8'h07;
        step();
        step();
        chk("pre_rst_cdb", 32'(bus.cdb_valid), 32'h7);
        reset = 1'b0;
        #1;
        chk("arst_cdb", {14'h0, bus.cdb_valid, bus.cdb_tag}, 32'h0);
        chk("arst_ready", 32'(bus.fu_ready), 32'hFF);
        chk("arst_err", 32'(bus.issue_err), 32'h0);
        bus.fu_done = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
